// File: rtl/latency_meter_pkg.sv
// Shared types, seven-segment glyphs and BCD helpers for latency_meter.
package latency_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Bit 0 = segment a ... bit 6 = segment g, bit 7 = decimal point.
  localparam logic [7:0] GLYPH_0     = 8'h3F;
  localparam logic [7:0] GLYPH_1     = 8'h06;
  localparam logic [7:0] GLYPH_2     = 8'h5B;
  localparam logic [7:0] GLYPH_3     = 8'h4F;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'h6D;
  localparam logic [7:0] GLYPH_6     = 8'h7D;
  localparam logic [7:0] GLYPH_7     = 8'h07;
  localparam logic [7:0] GLYPH_8     = 8'h7F;
  localparam logic [7:0] GLYPH_9     = 8'h6F;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] GLYPH_H     = 8'h76;
  localparam logic [7:0] GLYPH_E     = 8'h79;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_DP    = 8'h80;

  function automatic logic [7:0] bcd_to_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [23:0] bin_to_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Most significant differing digit decides.
  function automatic logic bcd_gt(input logic [23:0] a, input logic [23:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        gt      = a[i*4 +: 4] > b[i*4 +: 4];
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/latency_meter_bcd_counter.sv
// Decimal ripple counter; exposes both the held value and the value loaded this edge.
module bcd_counter #(
  parameter int DIGITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [23:0] count,
  output logic [23:0] count_next
);

  logic [DIGITS-1:0][3:0] dig_q, dig_d;

  always_comb begin
    logic carry;
    carry = inc;
    dig_d = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) dig_d[i] = (dig_q[i] == 4'd9) ? 4'd0 : dig_q[i] + 4'd1;
      carry = carry && (dig_q[i] == 4'd9);
    end
    if (clr) dig_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) dig_q <= '0;
    else       dig_q <= dig_d;
  end

  always_comb begin
    count      = '0;
    count_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      count[i*4 +: 4]      = dig_q[i];
      count_next[i*4 +: 4] = dig_d[i];
    end
  end

endmodule

// File: rtl/latency_meter.sv
// Trigger-to-light latency meter in microseconds with BCD and seven-segment output.
// Optional peak tracking is enabled by defining LATENCY_METER_MAX_EN.
module latency_meter
  import latency_meter_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic        light_on,
  input  logic        show_max,
  output logic        busy,
  output logic        result_valid,
  output logic        timeout,
  output logic [23:0] result_bcd,
  output logic [23:0] max_bcd,
  output logic [7:0]  segments [8]
);

  localparam int          TICK_CYC    = CLK_HZ / 1_000_000;
  localparam int          PW          = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [23:0] TIMEOUT_BCD = bin_to_bcd(TIMEOUT_US);
  localparam logic [19:0] TIMEOUT_BIN = 20'(TIMEOUT_US);

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [19:0]     us_q, us_d;
  logic [23:0]     result_q, result_d;
  logic            valid_q, valid_d;
  logic            tout_q, tout_d;
  logic [7:0]      segs_q [8];
  logic [7:0]      segs_d [8];

  logic            start, meas, tick;
  logic [23:0]     cnt_q, cnt_d, meas_val;
  logic [23:0]     max_val;
  logic            show_eff;

  assign start = (state_q == ST_IDLE) && trigger && !light_on;
  assign meas  = (state_q == ST_MEASURE);
  assign tick  = meas && (pre_q == PW'(TICK_CYC - 1));

  bcd_counter #(.DIGITS(6)) u_bcd (
    .clk        (clk),
    .reset      (reset),
    .clr        (start),
    .inc        (tick),
    .count      (cnt_q),
    .count_next (cnt_d)
  );

  // A tick landing on the sampling edge belongs to the reported value.
  assign meas_val = tick ? cnt_d : cnt_q;

  always_comb begin
    pre_d = pre_q;
    us_d  = us_q;
    if (start) begin
      pre_d = '0;
      us_d  = '0;
    end else if (meas) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) us_d = us_q + 20'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    valid_d  = 1'b0;
    tout_d   = tout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MEASURE;
          tout_d  = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (light_on) begin
          result_d = meas_val;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else if (us_d == TIMEOUT_BIN) begin
          result_d = TIMEOUT_BCD;
          tout_d   = 1'b1;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!light_on) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      us_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      us_q     <= us_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
    end
  end

`ifdef LATENCY_METER_MAX_EN
  logic [23:0] max_q, max_d;

  // Timed-out runs never reach this path: only a real light edge updates the peak.
  always_comb begin
    max_d = max_q;
    if (meas && light_on && bcd_gt(meas_val, max_q)) max_d = meas_val;
  end

  always_ff @(posedge clk) begin
    if (reset) max_q <= '0;
    else       max_q <= max_d;
  end

  assign max_val  = max_q;
  assign show_eff = show_max;
`else
  logic unused_show_max;
  assign unused_show_max = show_max;
  assign max_val         = '0;
  assign show_eff        = 1'b0;
`endif

  always_comb begin
    logic [23:0] src;
    logic        blank5, blank4;
    segs_d = '{default: GLYPH_BLANK};
    src    = show_eff ? max_val : result_q;
    blank5 = (src[23:20] == 4'd0);
    blank4 = blank5 && (src[19:16] == 4'd0);
    for (int i = 0; i < 4; i++) segs_d[i] = bcd_to_glyph(src[i*4 +: 4]);
    segs_d[3] = segs_d[3] | GLYPH_DP;
    segs_d[4] = blank4 ? GLYPH_BLANK : bcd_to_glyph(src[19:16]);
    segs_d[5] = blank5 ? GLYPH_BLANK : bcd_to_glyph(src[23:20]);
    if (meas)          segs_d[6] = GLYPH_DASH;
    else if (show_eff) segs_d[6] = GLYPH_H;
    segs_d[7] = tout_q ? GLYPH_E : GLYPH_BLANK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) segs_q[i] <= GLYPH_BLANK;
    end else begin
      for (int i = 0; i < 8; i++) segs_q[i] <= segs_d[i];
    end
  end

  assign busy         = meas;
  assign result_valid = valid_q;
  assign timeout      = tout_q;
  assign result_bcd   = result_q;
  assign max_bcd      = max_val;
  assign segments     = segs_q;

endmodule

// File: tb/tb_latency_meter.sv
// Randomized scenario bench for latency_meter against a cycle-count reference model.
module tb_latency_meter;

  localparam int CLK_HZ     = 4_000_000;
  localparam int TIMEOUT_US = 50;
  localparam int P          = CLK_HZ / 1_000_000;
  localparam int TO_CYC     = TIMEOUT_US * P;
`ifdef LATENCY_METER_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, trigger, light_on, show_max;
  logic        busy, result_valid, timeout;
  logic [23:0] result_bcd, max_bcd;
  logic [7:0]  segments [8];

  int n_tests = 0;
  int n_fail  = 0;
  int m_result = 0;
  int m_max    = 0;
  bit m_tout   = 1'b0;

  always #5 clk = ~clk;

  latency_meter #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clk          (clk),
    .reset        (reset),
    .trigger      (trigger),
    .light_on     (light_on),
    .show_max     (show_max),
    .busy         (busy),
    .result_valid (result_valid),
    .timeout      (timeout),
    .result_bcd   (result_bcd),
    .max_bcd      (max_bcd),
    .segments     (segments)
  );

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Expected glyph for display position i given the visible machine state.
  function automatic logic [7:0] exp_seg(input int i, input int val, input int mx,
                                         input bit bsy, input bit sm, input bit to);
    int src, s;
    src = (MAX_EN && sm) ? mx : val;
    s = src;
    for (int j = 0; j < i && j < 6; j++) s = s / 10;
    case (i)
      0, 1, 2: return glyph(s % 10);
      3:       return glyph(s % 10) | 8'h80;
      4:       return (src < 10000)  ? 8'h00 : glyph(s % 10);
      5:       return (src < 100000) ? 8'h00 : glyph(s % 10);
      6:       return bsy ? 8'h40 : ((MAX_EN && sm) ? 8'h76 : 8'h00);
      default: return to ? 8'h79 : 8'h00;
    endcase
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues a trigger, raises light_on so it is sampled n_light edges later
  // (0 = never), and observes result_valid/busy for a bounded number of edges.
  task automatic run_meas(input int n_light, input int budget,
                          output int pulses, output int vedge, output bit busy_ok);
    pulses  = 0;
    vedge   = -1;
    busy_ok = 1'b1;
    trigger  = 1'b1;
    light_on = 1'b0;
    step(1);
    trigger = 1'b0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (k == n_light) light_on = 1'b1;
      step(1);
      if (result_valid === 1'b1) begin
        pulses++;
        if (vedge < 0) vedge = k;
      end
      if (vedge < 0 && busy !== 1'b1) busy_ok = 1'b0;
      if (vedge >= 0 && busy !== 1'b0) busy_ok = 1'b0;
    end
  endtask

  task automatic test_single(input string name, input int n, input bit sm);
    int pulses, vedge, exp_edge, exp_val;
    bit busy_ok, exp_to;
    logic [7:0] es;
    show_max = sm;
    exp_to   = !(n > 0 && n <= TO_CYC);
    exp_edge = exp_to ? TO_CYC : n;
    exp_val  = exp_to ? TIMEOUT_US : n / P;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s idle_busy: got %b want 0", name, busy); end
    run_meas(n, ((n > TO_CYC) ? n : TO_CYC) + 4, pulses, vedge, busy_ok);
    m_result = exp_val;
    m_tout   = exp_to;
    if (MAX_EN && !exp_to && exp_val > m_max) m_max = exp_val;
    n_tests++;
    if (pulses !== 1) begin n_fail++; $display("FAIL %s pulses: got %0d want 1", name, pulses); end
    n_tests++;
    if (vedge !== exp_edge) begin n_fail++; $display("FAIL %s valid_edge: got %0d want %0d", name, vedge, exp_edge); end
    n_tests++;
    if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL %s busy_window: got %b want 1", name, busy_ok); end
    n_tests++;
    if (result_bcd !== to_bcd(exp_val)) begin n_fail++; $display("FAIL %s result_bcd: got %h want %h", name, result_bcd, to_bcd(exp_val)); end
    n_tests++;
    if (timeout !== exp_to) begin n_fail++; $display("FAIL %s timeout: got %b want %b", name, timeout, exp_to); end
    n_tests++;
    if (max_bcd !== to_bcd(m_max)) begin n_fail++; $display("FAIL %s max_bcd: got %h want %h", name, max_bcd, to_bcd(m_max)); end
    light_on = 1'b0;
    step(2);
    for (int i = 0; i < 8; i++) begin
      es = exp_seg(i, m_result, m_max, 1'b0, sm, m_tout);
      n_tests++;
      if (segments[i] !== es) begin n_fail++; $display("FAIL %s seg[%0d]: got %h want %h", name, i, segments[i], es); end
    end
  endtask

  task automatic test_reset();
    logic [7:0] es;
    reset = 1'b1; trigger = 1'b0; light_on = 1'b0; show_max = 1'b0;
    step(3);
    n_tests++;
    if ({busy, result_valid, timeout} !== 3'b000) begin n_fail++; $display("FAIL reset flags: got %b want 000", {busy, result_valid, timeout}); end
    n_tests++;
    if (result_bcd !== 24'h0 || max_bcd !== 24'h0) begin n_fail++; $display("FAIL reset bcd: got %h/%h want 0/0", result_bcd, max_bcd); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (segments[i] !== 8'h00) begin n_fail++; $display("FAIL reset seg[%0d]: got %h want 00", i, segments[i]); end
    end
    reset = 1'b0;
    step(1);
    for (int i = 0; i < 8; i++) begin
      es = exp_seg(i, 0, 0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (segments[i] !== es) begin n_fail++; $display("FAIL post_reset seg[%0d]: got %h want %h", i, segments[i], es); end
    end
  endtask

  task automatic test_basic();
    test_single("basic83", 83, 1'b0);
    repeat (3) test_single("basic_rand", int'($urandom_range(1, TO_CYC - 1)), 1'b0);
  endtask

  task automatic test_timeout();
    test_single("timeout", 0, 1'b0);
  endtask

  task automatic test_light_high();
    int bad;
    bad = 0;
    light_on = 1'b1;
    step(1);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (busy !== 1'b0 || result_valid !== 1'b0) bad++;
      step(1);
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL light_high ignored: got %0d busy/valid cycles want 0", bad); end
    n_tests++;
    if (timeout !== m_tout) begin n_fail++; $display("FAIL light_high timeout: got %b want %b", timeout, m_tout); end
    light_on = 1'b0;
    step(2);
  endtask

  task automatic test_retrigger_reset();
    logic [7:0] es;
    show_max = 1'b0;
    trigger = 1'b1; light_on = 1'b0;
    step(1);
    trigger = 1'b0;
    step(39);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL retrig busy: got %b want 1", busy); end
    n_tests++;
    if (segments[6] !== 8'h40) begin n_fail++; $display("FAIL retrig seg6: got %h want 40", segments[6]); end
    step(41);
    light_on = 1'b1;
    step(1);
    n_tests++;
    if (result_valid !== 1'b1 || result_bcd !== to_bcd(83 / P)) begin
      n_fail++; $display("FAIL retrig result: got %b/%h want 1/%h", result_valid, result_bcd, to_bcd(83 / P));
    end
    light_on = 1'b0;
    step(2);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(30);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    m_result = 0; m_max = 0; m_tout = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || result_bcd !== 24'h0 || timeout !== 1'b0 || max_bcd !== 24'h0) begin
      n_fail++; $display("FAIL mid_reset: got busy=%b res=%h to=%b max=%h want 0", busy, result_bcd, timeout, max_bcd);
    end
    step(1);
    for (int i = 0; i < 8; i++) begin
      es = exp_seg(i, 0, 0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (segments[i] !== es) begin n_fail++; $display("FAIL mid_reset seg[%0d]: got %h want %h", i, segments[i], es); end
    end
    step(3);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset stays_idle: got %b want 0", busy); end
  endtask

  task automatic test_max();
    test_single("max30", 30 * P + int'($urandom_range(0, P - 1)), 1'b1);
    test_single("max12", 12 * P + int'($urandom_range(0, P - 1)), 1'b1);
    test_single("max_to", 0, 1'b1);
    n_tests++;
    if (max_bcd !== (MAX_EN ? 24'h000030 : 24'h0)) begin
      n_fail++; $display("FAIL max final: got %h want %h", max_bcd, MAX_EN ? 24'h000030 : 24'h0);
    end
    show_max = 1'b0;
  endtask

  task automatic test_same_cycle();
    test_single("same_cycle", TO_CYC, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++)
      test_single("b2b", int'($urandom_range(1, TO_CYC + 30)), r[0]);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_light_high();
    test_retrigger_reset();
    test_max();
    test_same_cycle();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
